// File: rtl/multi_clkdiv_gen.sv
// multi_clkdiv_gen: NUM_CLOCKS divided, phase-offset, duty-programmable outputs from refclk with lock flag.
// Run-time reconfiguration port is compiled in only when MULTI_CLKDIV_GEN_RECONFIG_EN is defined.
module multi_clkdiv_gen #(
    parameter int                          NUM_CLOCKS  = 2,
    parameter int                          CNT_W       = 8,
    parameter logic [NUM_CLOCKS*CNT_W-1:0] DIV_INIT    = {NUM_CLOCKS{8'd4}},
    parameter logic [NUM_CLOCKS*CNT_W-1:0] HIGH_INIT   = {NUM_CLOCKS{8'd2}},
    parameter logic [NUM_CLOCKS*CNT_W-1:0] PHASE_INIT  = {NUM_CLOCKS{8'd0}},
    parameter int                          LOCK_CYCLES = 16
) (
    input  logic                                                refclk,
    input  logic                                                rst_n,
    output logic [NUM_CLOCKS-1:0]                               outclk,
    output logic                                                locked,
    input  logic                                                cfg_valid,
    output logic                                                cfg_ready,
    input  logic [((NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1)-1:0] cfg_chan,
    input  logic [CNT_W-1:0]                                    cfg_div,
    input  logic [CNT_W-1:0]                                    cfg_high,
    input  logic [CNT_W-1:0]                                    cfg_phase,
    output logic                                                cfg_err
);

    localparam int SC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [SC_W-1:0]       r_settle;
    logic [CNT_W-1:0]      r_cnt   [NUM_CLOCKS];
    logic [CNT_W-1:0]      w_div   [NUM_CLOCKS];
    logic [CNT_W-1:0]      w_high  [NUM_CLOCKS];
    logic [CNT_W-1:0]      w_phase [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] r_outclk;
    logic                  r_locked;
    logic                  r_cfg_ready;
    logic                  r_cfg_err;

    // Counter start value (div - phase) mod div, given phase < div.
    function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] div,
                                                 input logic [CNT_W-1:0] phase);
        return (phase == '0) ? '0 : (div - phase);
    endfunction

`ifdef MULTI_CLKDIV_GEN_RECONFIG_EN
    logic [CNT_W-1:0] r_div   [NUM_CLOCKS];
    logic [CNT_W-1:0] r_high  [NUM_CLOCKS];
    logic [CNT_W-1:0] r_phase [NUM_CLOCKS];
    logic             w_xfer;
    logic             w_legal;

    assign w_xfer  = cfg_valid && r_cfg_ready && (r_state == LOCKED);
    assign w_legal = (32'(cfg_chan) < NUM_CLOCKS) && (cfg_div != '0) && (cfg_phase < cfg_div);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                r_div[i]   <= DIV_INIT[i*CNT_W +: CNT_W];
                r_high[i]  <= HIGH_INIT[i*CNT_W +: CNT_W];
                r_phase[i] <= PHASE_INIT[i*CNT_W +: CNT_W];
            end
        end else if (w_xfer && w_legal) begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                if (32'(cfg_chan) == i) begin
                    r_div[i]   <= cfg_div;
                    r_high[i]  <= cfg_high;
                    r_phase[i] <= cfg_phase;
                end
            end
        end
    end

    assign w_div   = r_div;
    assign w_high  = r_high;
    assign w_phase = r_phase;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{cfg_valid, cfg_chan, cfg_div, cfg_high, cfg_phase};

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_const
        assign w_div[g]   = DIV_INIT[g*CNT_W +: CNT_W];
        assign w_high[g]  = HIGH_INIT[g*CNT_W +: CNT_W];
        assign w_phase[g] = PHASE_INIT[g*CNT_W +: CNT_W];
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            SETTLE: begin
                if (r_settle == SC_W'(LOCK_CYCLES - 1)) w_next = LOCKED;
            end
            LOCKED: begin
`ifdef MULTI_CLKDIV_GEN_RECONFIG_EN
                if (w_xfer && w_legal) w_next = UPDATE;
`endif
            end
`ifdef MULTI_CLKDIV_GEN_RECONFIG_EN
            UPDATE:  w_next = SETTLE;
`endif
            default: w_next = SETTLE;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SETTLE;
            r_settle    <= '0;
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_settle    <= (r_state == SETTLE && w_next == SETTLE) ? r_settle + SC_W'(1) : '0;
            r_locked    <= (w_next == LOCKED);
`ifdef MULTI_CLKDIV_GEN_RECONFIG_EN
            r_cfg_ready <= (w_next == LOCKED);
            r_cfg_err   <= w_xfer && !w_legal;
`else
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
`endif
        end
    end

    // Counters only run while locked; reloading on SETTLE entry keeps all channels mutually aligned.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                r_cnt[i] <= f_load(DIV_INIT[i*CNT_W +: CNT_W], PHASE_INIT[i*CNT_W +: CNT_W]);
            end
            r_outclk <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                if (r_state == LOCKED) begin
                    r_cnt[i] <= (r_cnt[i] >= w_div[i] - CNT_W'(1)) ? '0 : r_cnt[i] + CNT_W'(1);
                end else if (r_state != SETTLE && w_next == SETTLE) begin
                    r_cnt[i] <= f_load(w_div[i], w_phase[i]);
                end
                r_outclk[i] <= (r_state == LOCKED) && (w_next == LOCKED) && (r_cnt[i] < w_high[i]);
            end
        end
    end

    assign outclk    = r_outclk;
    assign locked    = r_locked;
    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;

endmodule
